// File: rtl/pmu_counter_bank.sv
// PMU event-counter bank: N 64-bit counters, CTRL, EVT_MASK and W1C OVF regs.
// Ports: AXI-side level read/write requests with 4-phase valid acks, events_i, pmu_irq.
module pmu_counter_bank #(
  parameter int N_COUNTERS = 23,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic [N_COUNTERS-1:0] events_i,
  input  logic                  counter_read_enable,
  input  logic [7:0]            counter_read_address,
  output logic                  counter_read_valid,
  output logic [CNT_WIDTH-1:0]  counter_read_data,
  input  logic                  counter_write_enable,
  input  logic [7:0]            counter_write_address,
  input  logic [CNT_WIDTH-1:0]  counter_write_data,
  output logic                  counter_write_valid,
  output logic                  pmu_irq
);

  localparam logic [7:0] A_CTRL = 8'h00;
  localparam logic [7:0] A_MASK = 8'h01;
  localparam logic [7:0] A_OVF  = 8'h02;
  localparam logic [7:0] A_CNT0 = 8'h08;

  typedef enum logic {R_IDLE, R_ACK} rd_state_e;
  typedef enum logic {W_IDLE, W_ACK} wr_state_e;

  logic [CNT_WIDTH-1:0]  cnt_q [N_COUNTERS];
  logic [CNT_WIDTH-1:0]  cnt_d [N_COUNTERS];
  logic                  gen_q, gen_d;
  logic [N_COUNTERS-1:0] mask_q, mask_d;
  logic [N_COUNTERS-1:0] ovf_q, ovf_d;
  logic [N_COUNTERS-1:0] inc, wrap, w1c;
  logic                  clr;
  logic                  irq_q;

  rd_state_e             rd_state_q;
  logic                  rd_arm_q;
  logic                  rvalid_q;
  logic [CNT_WIDTH-1:0]  rdata_q;
  logic [CNT_WIDTH-1:0]  rd_mux;

  wr_state_e             wr_state_q;
  logic                  wr_arm_q;
  logic                  wvalid_q;
  logic                  wr_fire;

  assign inc = {N_COUNTERS{gen_q}} & mask_q & events_i;

  // The arm flag forces a fresh low->high enable edge after reset.
  assign wr_fire = (wr_state_q == W_IDLE)
                 && counter_write_enable
                 && wr_arm_q;

  always_comb begin
    gen_d  = gen_q;
    mask_d = mask_q;
    clr    = 1'b0;
    w1c    = '0;
    wrap   = '0;
    if (wr_fire) begin
      if (counter_write_address == A_CTRL) begin
        gen_d = counter_write_data[0];
        clr   = counter_write_data[1];
      end
      if (counter_write_address == A_MASK)
        mask_d = N_COUNTERS'(counter_write_data);
      if (counter_write_address == A_OVF)
        w1c = N_COUNTERS'(counter_write_data);
    end
    for (int i = 0; i < N_COUNTERS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (wr_fire &&
                   counter_write_address == 8'(i) + A_CNT0) begin
        cnt_d[i] = counter_write_data;
      end else if (inc[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        wrap[i]  = &cnt_q[i];
      end
    end
    // New wrap beats a same-cycle W1C; clear_all beats both.
    ovf_d = clr ? '0 : ((ovf_q & ~w1c) | wrap);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      gen_q  <= 1'b0;
      mask_q <= '0;
      ovf_q  <= '0;
      irq_q  <= 1'b0;
      for (int i = 0; i < N_COUNTERS; i++)
        cnt_q[i] <= '0;
    end else begin
      gen_q  <= gen_d;
      mask_q <= mask_d;
      ovf_q  <= ovf_d;
      irq_q  <= |ovf_q;
      for (int i = 0; i < N_COUNTERS; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    rd_mux = '0;
    if (counter_read_address == A_CTRL)
      rd_mux = CNT_WIDTH'(gen_q);
    if (counter_read_address == A_MASK)
      rd_mux = CNT_WIDTH'(mask_q);
    if (counter_read_address == A_OVF)
      rd_mux = CNT_WIDTH'(ovf_q);
    for (int i = 0; i < N_COUNTERS; i++)
      if (counter_read_address == 8'(i) + A_CNT0)
        rd_mux = cnt_q[i];
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rd_state_q <= R_IDLE;
      rd_arm_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      unique case (rd_state_q)
        R_IDLE: begin
          if (!counter_read_enable) begin
            rd_arm_q <= 1'b1;
          end else if (rd_arm_q) begin
            rdata_q    <= rd_mux;
            rvalid_q   <= 1'b1;
            rd_state_q <= R_ACK;
          end
        end
        R_ACK: begin
          if (!counter_read_enable) begin
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            rd_arm_q   <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wr_state_q <= W_IDLE;
      wr_arm_q   <= 1'b0;
      wvalid_q   <= 1'b0;
    end else begin
      unique case (wr_state_q)
        W_IDLE: begin
          if (!counter_write_enable) begin
            wr_arm_q <= 1'b1;
          end else if (wr_arm_q) begin
            wvalid_q   <= 1'b1;
            wr_state_q <= W_ACK;
          end
        end
        W_ACK: begin
          if (!counter_write_enable) begin
            wvalid_q   <= 1'b0;
            wr_arm_q   <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  assign counter_read_valid  = rvalid_q;
  assign counter_read_data   = rdata_q;
  assign counter_write_valid = wvalid_q;
  assign pmu_irq             = irq_q;

endmodule

// File: tb/tb_pmu_counter_bank.sv
// Bench for pmu_counter_bank: directed scenarios then random traffic,
// checked by a scoreboard against a register-level reference model.
module tb_pmu_counter_bank;

  localparam int N = 23;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] ev = '0;
  logic         ren = 1'b0;
  logic [7:0]   raddr = '0;
  logic         rvalid;
  logic [W-1:0] rdata;
  logic         wen = 1'b0;
  logic [7:0]   waddr = '0;
  logic [W-1:0] wdata = '0;
  logic         wvalid;
  logic         irq;

  pmu_counter_bank #(.N_COUNTERS(N), .CNT_WIDTH(W)) dut (
    .S_AXI_ACLK           (clk),
    .S_AXI_ARESETN        (rst_n),
    .events_i             (ev),
    .counter_read_enable  (ren),
    .counter_read_address (raddr),
    .counter_read_valid   (rvalid),
    .counter_read_data    (rdata),
    .counter_write_enable (wen),
    .counter_write_address(waddr),
    .counter_write_data   (wdata),
    .counter_write_valid  (wvalid),
    .pmu_irq              (irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [W-1:0] m_cnt [N];
  logic [N-1:0] m_ovf = '0;
  logic [N-1:0] m_mask = '0;
  logic         m_gen = 1'b0;
  logic         m_irq = 1'b0;
  logic         m_rv = 1'b0;
  logic         m_wv = 1'b0;
  logic         r_rdy = 1'b0;
  logic         w_rdy = 1'b0;
  logic [W-1:0] exp_q [$];
  logic         mon_on = 1'b0;

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [W-1:0] rd_val(logic [7:0] a);
    if (a == 8'h00) return W'(m_gen);
    if (a == 8'h01) return W'(m_mask);
    if (a == 8'h02) return W'(m_ovf);
    if (int'(a) >= 8 && int'(a) < 8 + N) return m_cnt[int'(a) - 8];
    return '0;
  endfunction

  // Reference model: one call per clock edge, using the inputs of that edge.
  task automatic model_step();
    logic [N-1:0] wrap;
    logic [N-1:0] w1c;
    logic fire;
    logic clr;
    logic irq_n;
    if (!rst_n) begin
      foreach (m_cnt[i]) m_cnt[i] = '0;
      m_ovf = '0;
      m_mask = '0;
      m_gen = 1'b0;
      m_irq = 1'b0;
      m_rv = 1'b0;
      m_wv = 1'b0;
      r_rdy = 1'b0;
      w_rdy = 1'b0;
      exp_q.delete();
      return;
    end
    irq_n = |m_ovf;
    if (ren && r_rdy) begin
      exp_q.push_back(rd_val(raddr));
      m_rv = 1'b1;
      r_rdy = 1'b0;
    end else if (!ren) begin
      m_rv = 1'b0;
      r_rdy = 1'b1;
    end
    fire = wen && w_rdy;
    if (fire) begin
      m_wv = 1'b1;
      w_rdy = 1'b0;
    end else if (!wen) begin
      m_wv = 1'b0;
      w_rdy = 1'b1;
    end
    clr = fire && waddr == 8'h00 && wdata[1];
    wrap = '0;
    w1c = (fire && waddr == 8'h02) ? wdata[N-1:0] : '0;
    for (int i = 0; i < N; i++) begin
      if (clr) m_cnt[i] = '0;
      else if (fire && int'(waddr) == 8 + i) m_cnt[i] = wdata;
      else if (m_gen && m_mask[i] && ev[i]) begin
        if (m_cnt[i] == {W{1'b1}}) begin
          m_cnt[i] = '0;
          wrap[i] = 1'b1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
    m_ovf = clr ? '0 : ((m_ovf & ~w1c) | wrap);
    if (fire && waddr == 8'h00) m_gen = wdata[0];
    if (fire && waddr == 8'h01) m_mask = wdata[N-1:0];
    m_irq = irq_n;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Monitor: pops an expectation on every read-valid rise.
  logic         dv_prev = 1'b0;
  logic [W-1:0] exp_hold = '0;
  always @(negedge clk) begin
    if (mon_on) begin
      chk("rd_valid", W'(rvalid), W'(m_rv));
      chk("wr_valid", W'(wvalid), W'(m_wv));
      chk("irq", W'(irq), W'(m_irq));
      if (rvalid && !dv_prev) begin
        if (exp_q.size() == 0) chk("rd_unexpected", W'(exp_q.size()), W'(1));
        else exp_hold = exp_q.pop_front();
      end
      if (rvalid) chk("rd_data", rdata, exp_hold);
      else chk("rd_idle_data", rdata, '0);
      dv_prev = rvalid;
    end
  end

  task automatic rd(logic [7:0] a, int hold);
    ren = 1'b1;
    raddr = a;
    tick();
    repeat (hold) tick();
    ren = 1'b0;
    tick();
  endtask

  task automatic wr(logic [7:0] a, logic [W-1:0] d, int hold);
    wen = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    repeat (hold) tick();
    wen = 1'b0;
    tick();
  endtask

  function automatic logic [7:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return 8'(r);
    if (r == 3) return 8'($urandom_range(0, 255));
    return 8'(8 + $urandom_range(0, N - 1));
  endfunction

  function automatic logic [W-1:0] pick_data(logic [7:0] a);
    if (a == 8'h00)
      return W'({($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0)});
    if (a == 8'h01) return W'($urandom | $urandom);
    if (a == 8'h02) return W'($urandom);
    if ($urandom_range(0, 1) == 0)
      return {W{1'b1}} - W'($urandom_range(0, 5));
    return W'($urandom_range(0, 1000));
  endfunction

  initial begin
    foreach (m_cnt[i]) m_cnt[i] = '0;
    repeat (2) tick();
    mon_on = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    rd(8'h00, 0);
    rd(8'h01, 0);
    rd(8'h02, 0);
    rd(8'h08, 0);

    wr(8'h00, 64'h1, 0);
    wr(8'h01, 64'h1, 1);
    repeat (5) begin
      ev = 1;
      tick();
      ev = 0;
      tick();
    end
    rd(8'h08, 2);

    wr(8'h08, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    ev = 1;
    repeat (2) tick();
    ev = 0;
    tick();
    rd(8'h08, 0);
    rd(8'h02, 0);
    wr(8'h02, 64'h1, 0);
    rd(8'h02, 0);
    tick();

    wr(8'h01, 64'h2, 0);
    ev = 3;
    repeat (10) tick();
    ev = 0;
    rd(8'h08, 0);
    rd(8'h09, 0);
    wr(8'h00, 64'h0, 0);
    ev = 3;
    repeat (10) tick();
    ev = 0;
    rd(8'h09, 0);

    wr(8'h00, 64'h1, 0);
    wr(8'h01, {W{1'b1}}, 0);
    rd(8'h01, 0);
    wen = 1'b1;
    waddr = 8'h0A;
    wdata = 64'd100;
    ev = 4;
    tick();
    ev = 0;
    wen = 1'b0;
    tick();
    rd(8'h0A, 0);

    wr(8'h08, {W{1'b1}}, 0);
    wen = 1'b1;
    waddr = 8'h02;
    wdata = 64'h1;
    ev = 1;
    tick();
    ev = 0;
    wen = 1'b0;
    tick();
    rd(8'h02, 0);
    wr(8'h02, 64'h1, 0);

    ev = 3;
    rd(8'h09, 4);
    ev = 0;
    ren = 1'b1;
    raddr = 8'h09;
    wen = 1'b1;
    waddr = 8'h09;
    wdata = 64'd77;
    tick();
    ren = 1'b0;
    wen = 1'b0;
    tick();
    rd(8'h09, 0);

    wr(8'h00, 64'h3, 0);
    rd(8'h00, 0);
    rd(8'h08, 0);
    rd(8'h09, 0);
    rd(8'h0A, 0);
    rd(8'h02, 0);
    rd(8'h05, 0);
    wr(8'h05, 64'd123, 1);
    rd(8'h05, 0);

    ren = 1'b1;
    raddr = 8'h00;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    ren = 1'b0;
    tick();
    ren = 1'b1;
    tick();
    ren = 1'b0;
    tick();

    wr(8'h00, 64'h1, 0);
    wr(8'h01, {W{1'b1}}, 0);
    for (int c = 0; c < 600; c++) begin
      ev = N'($urandom);
      if (!ren) raddr = pick_addr();
      if ($urandom_range(0, 2) == 0) ren = !ren;
      if (!wen) begin
        waddr = pick_addr();
        wdata = pick_data(waddr);
      end
      if ($urandom_range(0, 2) == 0) wen = !wen;
      tick();
    end
    ev = 0;
    ren = 1'b0;
    wen = 1'b0;
    repeat (3) tick();
    chk("queue_drain", W'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
